axist_csr_test_seq: RTL

- Autonomous Avalon-MM master that runs one AXI-ST link test through the AXI-ST CSR block on the management side.
- Sits directly upstream of the CSR slave port: its outputs drive the write address, write data, write-enable and read-enable inputs of the DUT top; it consumes read data, read-valid and wait-request.
- Sequence: wait for link online, program delay X/Y/Z and pattern-generator config, poll checker status, report pass / fail / timeout.

---
 rtl/axist_csr_test_seq.sv | 251 +++++++++++++++++++++++++
 1 files changed

// File: rtl/axist_csr_test_seq.sv
// Autonomous Avalon-MM master that runs one AXI-ST link test through the CSR block.
// Optional: define AXIST_SEQ_RDBACK_EN to read back and verify each configuration write.
module axist_csr_test_seq #(
  parameter logic [31:0] DLY_X_ADDR = 32'h0000_1010,
  parameter logic [31:0] DLY_Y_ADDR = 32'h0000_1014,
  parameter logic [31:0] DLY_Z_ADDR = 32'h0000_1018,
  parameter logic [31:0] CFG_ADDR   = 32'h0000_1000,
  parameter logic [31:0] STAT_ADDR  = 32'h0000_1020,
  parameter int unsigned ONLINE_TMO = 4096,
  parameter int unsigned POLL_GAP   = 16,
  parameter int unsigned POLL_MAX   = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [1:0]  i_patgen_sel,
  input  logic [8:0]  i_patgen_cnt,
  input  logic        i_cntuspatt_en,
  input  logic [31:0] i_delay_x,
  input  logic [31:0] i_delay_y,
  input  logic [31:0] i_delay_z,
  input  logic        i_tx_online,
  input  logic        i_rx_online,
  output logic [31:0] o_wr_addr,
  output logic [31:0] o_wrdata,
  output logic        o_wren,
  output logic        o_rden,
  input  logic        i_waitreq,
  input  logic        i_readdatavalid,
  input  logic [31:0] i_readdata,
  output logic        o_busy,
  output logic        o_pass,
  output logic        o_fail,
  output logic        o_timeout,
  output logic [3:0]  o_state
);

  localparam int unsigned TW = $clog2(ONLINE_TMO + 1);
  localparam int unsigned GW = $clog2(POLL_GAP + 1);
  localparam int unsigned PW = $clog2(POLL_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_WAIT_ONLINE = 4'd1,
    S_WR_DX       = 4'd2,
    S_WR_DY       = 4'd3,
    S_WR_DZ       = 4'd4,
    S_WR_CFG      = 4'd5,
    S_GAP         = 4'd6,
    S_RD_REQ      = 4'd7,
    S_RD_WAIT     = 4'd8,
`ifdef AXIST_SEQ_RDBACK_EN
    S_RB_DX       = 4'd10,
    S_RB_DY       = 4'd11,
    S_RB_DZ       = 4'd12,
    S_RB_CFG      = 4'd13,
`endif
    S_DONE        = 4'd9
  } state_t;

  state_t        state_q, state_d, wr_next;
  logic [31:0]   addr_d, wrdata_d;
  logic          wren_d, rden_d, pass_d, fail_d, tmo_flag_d;
  logic [31:0]   dx_q, dy_q, dz_q, cfg_q, dx_d, dy_d, dz_d, cfg_d;
  logic          online, online_q, online_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [PW-1:0] poll_q, poll_d;
  logic          advance;

  assign online  = i_tx_online & i_rx_online;
  assign o_busy  = (state_q != S_IDLE) && (state_q != S_DONE);
  assign o_state = state_q;

`ifndef AXIST_SEQ_RDBACK_EN
  logic rd_unused;
  assign rd_unused = ^i_readdata[31:2];
`endif

  // Write that follows the one just completed (and verified, when readback is built in).
  always_comb begin
    case (state_q)
      S_WR_DX:  wr_next = S_WR_DY;
      S_WR_DY:  wr_next = S_WR_DZ;
      S_WR_DZ:  wr_next = S_WR_CFG;
`ifdef AXIST_SEQ_RDBACK_EN
      S_RB_DX:  wr_next = S_WR_DY;
      S_RB_DY:  wr_next = S_WR_DZ;
      S_RB_DZ:  wr_next = S_WR_CFG;
`endif
      default:  wr_next = S_GAP;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = o_wr_addr;
    wrdata_d   = o_wrdata;
    wren_d     = o_wren;
    rden_d     = o_rden;
    pass_d     = o_pass;
    fail_d     = o_fail;
    tmo_flag_d = o_timeout;
    dx_d       = dx_q;
    dy_d       = dy_q;
    dz_d       = dz_q;
    cfg_d      = cfg_q;
    online_d   = 1'b0;
    tmo_d      = tmo_q;
    gap_d      = '0;
    poll_d     = poll_q;
    advance    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (i_start) begin
          dx_d       = i_delay_x;
          dy_d       = i_delay_y;
          dz_d       = i_delay_z;
          cfg_d      = {19'd0, i_cntuspatt_en, i_patgen_cnt, i_patgen_sel, 1'b1};
          pass_d     = 1'b0;
          fail_d     = 1'b0;
          tmo_flag_d = 1'b0;
          tmo_d      = '0;
          poll_d     = '0;
          state_d    = S_WAIT_ONLINE;
        end
      end
      S_WAIT_ONLINE: begin
        online_d = online;
        if (online && online_q) begin
          state_d  = S_WR_DX;
          wren_d   = 1'b1;
          addr_d   = DLY_X_ADDR;
          wrdata_d = dx_q;
        end else if (tmo_q >= TW'(ONLINE_TMO - 1)) begin
          tmo_flag_d = 1'b1;
          state_d    = S_DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WR_DX, S_WR_DY, S_WR_DZ, S_WR_CFG: begin
        if (!i_waitreq) begin
`ifdef AXIST_SEQ_RDBACK_EN
          // Readback states sit at write encoding + 8; address and data stay on the bus.
          wren_d  = 1'b0;
          rden_d  = 1'b1;
          state_d = state_t'(state_q + 4'd8);
`else
          advance = 1'b1;
`endif
        end
      end
`ifdef AXIST_SEQ_RDBACK_EN
      S_RB_DX, S_RB_DY, S_RB_DZ, S_RB_CFG: begin
        if (o_rden) begin
          if (!i_waitreq) rden_d = 1'b0;
        end else if (i_readdatavalid) begin
          if (i_readdata == o_wrdata) begin
            advance = 1'b1;
          end else begin
            fail_d  = 1'b1;
            state_d = S_DONE;
          end
        end
      end
`endif
      S_GAP: begin
        if (gap_q == GW'(POLL_GAP - 1)) begin
          state_d = S_RD_REQ;
          rden_d  = 1'b1;
          addr_d  = STAT_ADDR;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      S_RD_REQ: begin
        if (!i_waitreq) begin
          rden_d  = 1'b0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (i_readdatavalid) begin
          if (poll_q != PW'(POLL_MAX)) poll_d = poll_q + 1'b1;
          if (i_readdata[1]) begin
            pass_d  = i_readdata[0];
            fail_d  = !i_readdata[0];
            state_d = S_DONE;
          end else if (poll_d == PW'(POLL_MAX)) begin
            tmo_flag_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            state_d = S_GAP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      state_d = wr_next;
      wren_d  = (wr_next != S_GAP);
      case (wr_next)
        S_WR_DY:  begin addr_d = DLY_Y_ADDR; wrdata_d = dy_q;  end
        S_WR_DZ:  begin addr_d = DLY_Z_ADDR; wrdata_d = dz_q;  end
        S_WR_CFG: begin addr_d = CFG_ADDR;   wrdata_d = cfg_q; end
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      o_wr_addr <= '0;
      o_wrdata  <= '0;
      o_wren    <= 1'b0;
      o_rden    <= 1'b0;
      o_pass    <= 1'b0;
      o_fail    <= 1'b0;
      o_timeout <= 1'b0;
      dx_q      <= '0;
      dy_q      <= '0;
      dz_q      <= '0;
      cfg_q     <= '0;
      online_q  <= 1'b0;
      tmo_q     <= '0;
      gap_q     <= '0;
      poll_q    <= '0;
    end else begin
      state_q   <= state_d;
      o_wr_addr <= addr_d;
      o_wrdata  <= wrdata_d;
      o_wren    <= wren_d;
      o_rden    <= rden_d;
      o_pass    <= pass_d;
      o_fail    <= fail_d;
      o_timeout <= tmo_flag_d;
      dx_q      <= dx_d;
      dy_q      <= dy_d;
      dz_q      <= dz_d;
      cfg_q     <= cfg_d;
      online_q  <= online_d;
      tmo_q     <= tmo_d;
      gap_q     <= gap_d;
      poll_q    <= poll_d;
    end
  end

endmodule
